// File: rtl/ucsbece154b_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : ucsbece154b_fetch_queue
// Brief   : Dual-issue instruction fetch queue. It accepts up to two
//           instructions per cycle and presents the two oldest entries to the
//           decode slots. A flush empties the queue in one cycle.
//           Defining FETCHQ_BYPASS_EN lets an empty queue forward incoming
//           instructions to the slot outputs in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module ucsbece154b_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               EnqCnt_i,
    input  logic [XLEN-1:0]          EnqPC_i,
    input  logic [XLEN-1:0]          EnqInstr1_i,
    input  logic [XLEN-1:0]          EnqInstr2_i,
    output logic                     EnqReady_o,
    output logic [XLEN-1:0]          InstrD1_o,
    output logic [XLEN-1:0]          PCD1_o,
    output logic [XLEN-1:0]          InstrD2_o,
    output logic [XLEN-1:0]          PCD2_o,
    output logic                     ValidD1_o,
    output logic                     ValidD2_o,
    input  logic                     Issue1_i,
    input  logic                     Issue2_i,
    input  logic                     Flush_i,
    output logic [$clog2(DEPTH):0]   Count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] c_NOP       = XLEN'(32'h0000_0013);
    localparam logic [AW:0]     c_READY_MAX = (AW+1)'(DEPTH - 2);

    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_instr [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;

    logic [1:0]      w_offer;
    logic            w_ready;
    logic [1:0]      w_enq;
    logic [AW-1:0]   w_head1;
    logic [AW-1:0]   w_tail1;
    logic [XLEN-1:0] w_pc2_in;
    logic            w_bypass;
    logic            w_pop1;
    logic            w_pop2;
    logic [1:0]      w_pop;
    logic            w_we0;
    logic            w_we1;

    assign w_offer  = (EnqCnt_i == 2'd3) ? 2'd0 : EnqCnt_i;
    assign w_ready  = (r_count <= c_READY_MAX);
    assign w_enq    = (w_ready && !Flush_i) ? w_offer : 2'd0;
    assign w_head1  = r_head + AW'(1);
    assign w_tail1  = r_tail + AW'(1);
    assign w_pc2_in = EnqPC_i + XLEN'(4);

`ifdef FETCHQ_BYPASS_EN
    assign w_bypass = (r_count == '0) && (w_enq != 2'd0);
`else
    assign w_bypass = 1'b0;
`endif

    assign EnqReady_o = w_ready;
    assign Count_o    = r_count;

    always_comb begin
        ValidD1_o = (r_count != '0);
        ValidD2_o = (r_count >= (AW+1)'(2));
        PCD1_o    = r_pc[r_head];
        InstrD1_o = r_instr[r_head];
        PCD2_o    = r_pc[w_head1];
        InstrD2_o = r_instr[w_head1];
        if (w_bypass) begin
            ValidD1_o = 1'b1;
            ValidD2_o = (w_enq == 2'd2);
            PCD1_o    = EnqPC_i;
            InstrD1_o = EnqInstr1_i;
            PCD2_o    = w_pc2_in;
            InstrD2_o = EnqInstr2_i;
        end
        if (!ValidD1_o) begin
            PCD1_o    = '0;
            InstrD1_o = c_NOP;
        end
        if (!ValidD2_o) begin
            PCD2_o    = '0;
            InstrD2_o = c_NOP;
        end
    end

    assign w_pop1 = Issue1_i & ValidD1_o;
    assign w_pop2 = Issue1_i & Issue2_i & ValidD2_o;
    assign w_pop  = {1'b0, w_pop1} + {1'b0, w_pop2};

    // Bypassed entries that decode consumes are skipped: head still advances past their slots.
    assign w_we0 = (w_enq != 2'd0) && !(w_bypass && w_pop1);
    assign w_we1 = (w_enq == 2'd2) && !(w_bypass && w_pop2);

    always_ff @(posedge clk) begin
        if (w_we0) begin
            r_pc[r_tail]    <= EnqPC_i;
            r_instr[r_tail] <= EnqInstr1_i;
        end
        if (w_we1) begin
            r_pc[w_tail1]    <= w_pc2_in;
            r_instr[w_tail1] <= EnqInstr2_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (Flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= r_tail + AW'(w_enq);
            r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: doc/ucsbece154b_fetch_queue.md
# ucsbece154b_fetch_queue

Dual-issue instruction fetch queue feeding the two decode slots of the superscalar pipeline. Accepts up to two sequential instructions per cycle from instruction memory, presents the two oldest entries to decode as slot 1 and slot 2, and retires 0, 1 or 2 entries per cycle according to the issue decision returned by the controller. A mispredict flush empties it in one cycle.

## Interface
- DEPTH, 8: number of entries; power of two, 4..64.
- XLEN, 32: PC and instruction width.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- EnqCnt_i  in  2  instructions offered this cycle: 0, 1 or 2; 3 treated as 0.
- EnqPC_i  in  XLEN  PC of first offered instruction; second is EnqPC_i+4.
- EnqInstr1_i, EnqInstr2_i  in  XLEN each  offered instructions, oldest first.
- EnqReady_o  out  1  at least 2 free entries.
- InstrD1_o, PCD1_o  out  XLEN each  oldest entry (slot 1).
- InstrD2_o, PCD2_o  out  XLEN each  second-oldest entry (slot 2).
- ValidD1_o, ValidD2_o  out  1 each  slot holds a real entry.
- Issue1_i  in  1  slot 1 consumed by decode this cycle.
- Issue2_i  in  1  slot 2 consumed this cycle (valid only with Issue1_i).
- Flush_i  in  1  mispredict; discard all contents.
- Count_o  out  clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries of {PC, instr}; head and tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH; separate occupancy counter.
- Enqueue: when EnqReady_o=1 and Flush_i=0, write EnqCnt_i entries at tail, tail += EnqCnt_i. When EnqReady_o=0 the offer is dropped; upstream holds it.
- Dequeue: pop = (Issue1_i & ValidD1_o) + (Issue1_i & Issue2_i & ValidD2_o). Issue2_i without Issue1_i, or issue of an invalid slot, pops nothing for that slot. head += pop.
- Occupancy: Count_next = Count + enq - pop; simultaneous enqueue and dequeue allowed in all states including full-minus-2 and empty.
- Outputs: slot 1 = entry[head], slot 2 = entry[head+1 mod DEPTH]. ValidD1_o = Count>=1, ValidD2_o = Count>=2. Invalid slot drives InstrDx_o = 0x00000013 (NOP), PCDx_o = 0.
- EnqReady_o = (DEPTH - Count) >= 2; computed from current Count only, not from this cycle's pop.
- Flush_i: next cycle Count=0, head=tail=0; same-cycle enqueue and pop ignored. Flush has priority over everything except reset.
- Reset (any time, including mid-operation): Count=0, head=tail=0, ValidD1_o=ValidD2_o=0, InstrDx_o=0x00000013, PCDx_o=0, EnqReady_o=1. Array contents need not be cleared.

## Timing
- Enqueue-to-output latency 1 cycle: entry written at edge N is visible on slot outputs after edge N (cycle N+1) when it is at head or head+1.
- Dequeue takes effect at the clock edge; next oldest entries appear the following cycle.
- Slot outputs and valids are combinational from registered state only (no path from Issue*_i or Flush_i to outputs).
- Full: Count=DEPTH, EnqReady_o=0. Count=DEPTH-1 also gives EnqReady_o=0.
- Wrap: an enqueue of 2 with tail=DEPTH-1 writes entries DEPTH-1 and 0.

## Configuration
- FETCHQ_BYPASS_EN defined: when Count=0 and EnqCnt_i>0 and Flush_i=0, slots show the incoming instructions the same cycle (ValidD1_o=1, ValidD2_o=(EnqCnt_i==2)); issued ones are not written, unissued ones are written at tail. Creates combinational path EnqInstr/EnqPC/EnqCnt -> slot outputs.
- Undefined: no bypass; 1-cycle latency always, outputs purely from registered state.

## Test plan
- Reset then EnqCnt=2, EnqPC=0x100, instrs A,B, no issue -> next cycle ValidD1/D2=1, PCD1=0x100, PCD2=0x104, Count=2.
- Queue holds A,B,C; Issue1=1, Issue2=0 -> next cycle slot1=B, slot2=C, Count=2; Issue2=1 alone -> no pop.
- Fill to DEPTH=8 with issue held 0 -> EnqReady_o=0 at Count=7 and 8, further offers dropped, Count stays 8; then Issue1=Issue2=1 with EnqCnt=2 same cycle -> Count stays 8 only if EnqReady was 1 (at 8: Count=6).
- Wrap: 20 cycles of EnqCnt=2 with Issue1=Issue2=1 -> PC sequence on slot1 increments by 8 per cycle, no loss at index 7->0.
- Flush_i=1 with Count=5 and EnqCnt=2 -> next cycle Count=0, ValidD1=0, InstrD1=0x00000013.
- reset_n low asynchronously mid-cycle with Count=4 -> outputs immediately at reset values, Count=0, EnqReady_o=1.
